receiver: RTL and testbench
===========================

# receiver

Serial frame receiver sitting directly downstream of the `transmitter` stage, consuming its one-bit-per-clock serial line. It detects the start bit, deserialises 8 data bits (LSB first), optionally checks an odd parity bit and samples the stop bit. It then presents the byte with a one-cycle `valid` pulse and error flags to the parallel side.

## Interface
- No parameters; frame widths are fixed constants in `rx_pkg`.
- `clk`  input  1  clock; one line bit per rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `parity`  input  1  1 = the frame carries a parity bit; latched at start-bit detection.
- `data_in`  input  1  serial line; idles high.
- `data_out`  output  8  received byte; holds its value until the next frame completes.
- `valid`  output  1  one-cycle pulse when `data_out` and the error flags update.
- `parity_error`  output  1  odd-parity mismatch on the last frame; 0 if that frame had no parity bit.
- `frame_error`  output  1  stop bit sampled low on the last frame; see Configuration.
- `busy`  output  1  high in every state except IDLE.

## Operation
- Frame: idle 1, start 0, d0..d7 (LSB first), optional parity P, stop 1.
- Odd parity: P = ~^d[7:0], so the total count of ones in d plus P is odd.
- FSM states:
  - IDLE: `data_in` == 0 → DATA; latch `parity` into `par_en_q`; clear the bit counter and running parity.
  - DATA: shift `data_in` into bit[cnt]; XOR it into running parity; cnt++. When cnt == 7 → PARITY if `par_en_q`, else STOP.
  - PARITY: `perr_n` = running ^ `data_in` ^ 1 → STOP.
  - STOP: sample `data_in`; transfer the shift register to `data_out`; update both error flags; pulse `valid`; → IDLE.
- Bit counter: 3-bit, wraps naturally from 7 to 0, used only in DATA.
- Back-to-back frames: the state after STOP is IDLE, which can detect the next start bit on the very next edge. No gap is required.
- Changes on `parity` while `busy` = 1 are ignored until the next start bit.
- There is no oversampling or glitch filter. Any 0 seen in IDLE starts a frame.
- Asynchronous reset, also mid-frame: state → IDLE, counter and shift register → 0; `data_out` = 8'h00, `valid` = 0, `parity_error` = 0, `frame_error` = 0, `busy` = 0. A partially received frame is discarded with no `valid`.

## Timing
- Start bit is sampled at edge S.
- d0..d7 are sampled at edges S+1..S+8.
- Parity bit, if enabled, is sampled at S+9.
- Stop bit is sampled at S+10 with parity, or at S+9 without.
- `valid` rises at the stop-sample edge and falls at the next edge. `data_out` and the flags change on that same edge.
- Frame length is 11 cycles with parity and 10 without, matching the transmitter.
- Every output is registered; there is no combinational path from input to output.

## Configuration
- Macro `RX_FRAME_CHECK_EN`:
  - Defined: STOP drives `frame_error` = ~`data_in`. When `frame_error` is 1, the frame is still delivered with `valid`.
  - Undefined: `frame_error` is tied to 0, the stop-bit value is ignored, and no extra logic is generated. STOP still occupies one cycle, so timing is identical.

## Structure
- Package `rx_pkg` holds:
  - `typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t`
  - `localparam DATA_BITS = 8`
  - `localparam PARITY_ODD = 1'b1`
- One sub-module, `rx_shift_register`: 8-bit serial-in/parallel-out with async active-low reset and a shift enable, inserting at the MSB so that d0 ends up in bit 0.
- The FSM, counter, parity accumulator and output registers live in `receiver`.
- Existing `counter` and `comparetor` may be instantiated for cnt/cnt_end.

## Test plan
- `parity`=1; frame 0xA5 with P=1 → at S+10 `valid` pulses for one cycle, `data_out`=8'hA5, `parity_error`=0, `frame_error`=0.
- `parity`=1; frame 0xA5 with P=0 → `data_out`=8'hA5, `parity_error`=1 at S+10.
- `parity`=0; frame 0x3C → `valid` at S+9, `data_out`=8'h3C, `parity_error`=0. Toggle `parity` mid-frame and confirm there is no effect.
- `RX_FRAME_CHECK_EN` defined; frame 0x81 with stop bit = 0 → `valid` with `frame_error`=1. Build without the macro → `frame_error`=0.
- Two back-to-back frames, 0x12 then 0xFE, with `parity`=1 and the second start bit on the cycle right after the first stop bit → two `valid` pulses 11 cycles apart carrying 8'h12 then 8'hFE.
- Assert `reset` at S+4, release it, then send 0x55 → no `valid` for the aborted frame, all outputs at reset values, then a clean 8'h55 delivery.

Source files
------------

// File: rtl/rx_pkg.sv
// Shared types and constants for the serial frame receiver.
package rx_pkg;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;

  localparam int unsigned DATA_BITS = 8;
  localparam logic PARITY_ODD = 1'b1;

  // High when data bits plus parity bit hold the wrong number of ones.
  function automatic logic parity_mismatch(input logic running, input logic par_bit);
    return running ^ par_bit ^ PARITY_ODD;
  endfunction

endpackage

// File: rtl/rx_if.sv
// Serial-line / parallel-side signal bundle for the receiver.
interface rx_if;
  import rx_pkg::*;

  logic                 parity;
  logic                 data_in;
  logic [DATA_BITS-1:0] data_out;
  logic                 valid;
  logic                 parity_error;
  logic                 frame_error;
  logic                 busy;

  modport master (
    output parity, data_in,
    input  data_out, valid, parity_error, frame_error, busy
  );

  modport slave (
    input  parity, data_in,
    output data_out, valid, parity_error, frame_error, busy
  );
endinterface

// File: rtl/rx_shift_register.sv
// Serial-in/parallel-out register; new bits enter at the MSB so d0 lands in bit 0.
module rx_shift_register
  import rx_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 shift_en,
  input  logic                 din,
  output logic [DATA_BITS-1:0] q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      q <= '0;
    else if (shift_en)
      q <= {din, q[DATA_BITS-1:1]};
  end

endmodule

// File: rtl/receiver.sv
// Serial frame receiver: start, 8 data bits LSB first, optional odd parity, stop.
// Stop-bit checking is enabled by defining RX_FRAME_CHECK_EN.
module receiver
  import rx_pkg::*;
(
  input  logic clk,
  input  logic reset,
  rx_if.slave  rx
);

  rx_state_t            state_q, state_d;
  logic [2:0]           cnt_q;
  logic                 cnt_end;
  logic                 par_en_q;
  logic                 run_par_q;
  logic                 perr_q;
  logic                 start_det;
  logic                 shift_en;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q;
  logic                 perr_out_q;

  assign cnt_end = (cnt_q == 3'd7);

  always_comb begin
    state_d   = state_q;
    start_det = 1'b0;
    shift_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rx.data_in) begin
          state_d   = DATA;
          start_det = 1'b1;
        end
      end
      DATA: begin
        shift_en = 1'b1;
        if (cnt_end)
          state_d = par_en_q ? PARITY : STOP;
      end
      PARITY:  state_d = STOP;
      STOP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q     <= '0;
      par_en_q  <= 1'b0;
      run_par_q <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      if (start_det) begin
        par_en_q  <= rx.parity;
        cnt_q     <= '0;
        run_par_q <= 1'b0;
      end else if (shift_en) begin
        cnt_q     <= cnt_q + 3'd1;
        run_par_q <= run_par_q ^ rx.data_in;
      end
      if (state_q == PARITY)
        perr_q <= parity_mismatch(run_par_q, rx.data_in);
    end
  end

  rx_shift_register u_shift (
    .clk      (clk),
    .reset    (reset),
    .shift_en (shift_en),
    .din      (rx.data_in),
    .q        (shift_q)
  );

  // Parallel outputs update only at the stop-bit edge; valid is the registered STOP marker.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q     <= '0;
      valid_q    <= 1'b0;
      perr_out_q <= 1'b0;
    end else begin
      valid_q <= (state_q == STOP);
      if (state_q == STOP) begin
        data_q     <= shift_q;
        perr_out_q <= par_en_q & perr_q;
      end
    end
  end

`ifdef RX_FRAME_CHECK_EN
  logic ferr_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      ferr_q <= 1'b0;
    else if (state_q == STOP)
      ferr_q <= ~rx.data_in;
  end

  assign rx.frame_error = ferr_q;
`else
  assign rx.frame_error = 1'b0;
`endif

  assign rx.data_out     = data_q;
  assign rx.valid        = valid_q;
  assign rx.parity_error = perr_out_q;
  assign rx.busy         = (state_q != IDLE);

endmodule

// File: tb/tb_receiver.sv
// Randomized bench for receiver against a frame-level model of expected deliveries.
module tb_receiver;

  typedef struct {
    int         start;
    int         due;
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

`ifdef RX_FRAME_CHECK_EN
  localparam bit FCHK = 1'b1;
`else
  localparam bit FCHK = 1'b0;
`endif

  logic clk;
  logic reset;
  rx_if bus ();

  receiver dut (
    .clk   (clk),
    .reset (reset),
    .rx    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t       q[$];
  int         edge_n = 0;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_data = 8'h00;
  logic       exp_perr = 1'b0;
  logic       exp_ferr = 1'b0;
  int         last_v = -100;
  int         prev_v = -100;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", name, edge_n, got, exp);
    end
  endtask

  // Per-cycle comparison against the model, just after each sampling edge.
  always begin
    bit due_now;
    bit exp_busy;
    @(posedge clk);
    #1;
    edge_n++;
    due_now = (q.size() > 0) && (q[0].due == edge_n);
    if (due_now) begin
      exp_data = q[0].data;
      exp_perr = q[0].perr;
      exp_ferr = q[0].ferr;
      q.pop_front();
      prev_v = last_v;
      last_v = edge_n;
    end
    exp_busy = (q.size() > 0) && (q[0].start <= edge_n);
    check("valid",        bus.valid,        due_now);
    check("data_out",     bus.data_out,     exp_data);
    check("parity_error", bus.parity_error, exp_perr);
    check("frame_error",  bus.frame_error,  exp_ferr);
    check("busy",         bus.busy,         exp_busy);
  end

  // Drives one frame; returns with the stop bit on the line but not yet sampled.
  task automatic send_frame(input logic [7:0] d, input bit pe, input bit bad_par,
                            input bit stop_bit, input bit toggle);
    logic bits [0:10];
    int   n;
    logic p;
    exp_t e;
    p = ($countones(d) % 2 == 0) ? 1'b1 : 1'b0;
    if (bad_par) p = ~p;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = d[i];
    n = 9;
    if (pe) begin
      bits[n] = p;
      n++;
    end
    bits[n] = stop_bit;
    n++;
    @(negedge clk);
    bus.parity  = pe;
    bus.data_in = bits[0];
    e.start = edge_n + 1;
    e.due   = e.start + n - 1;
    e.data  = d;
    e.perr  = pe && (($countones(d) + int'(p)) % 2 == 0);
    e.ferr  = FCHK && !stop_bit;
    q.push_back(e);
    for (int k = 1; k < n; k++) begin
      @(negedge clk);
      bus.data_in = bits[k];
      if (toggle) bus.parity = $urandom_range(0, 1);
    end
  endtask

  task automatic idle(input int k);
    repeat (k) begin
      @(negedge clk);
      bus.data_in = 1'b1;
      bus.parity  = $urandom_range(0, 1);
    end
  endtask

  initial begin
    exp_t ab;
    logic [7:0] d;
    reset       = 1'b0;
    bus.data_in = 1'b1;
    bus.parity  = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    check("reset data_out", bus.data_out, 8'h00);
    check("reset busy",     bus.busy,     1'b0);
    idle(2);

    // Good parity 0xA5
    send_frame(8'hA5, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(1);
    check("A5 valid",    bus.valid,        1'b1);
    check("A5 data",     bus.data_out,     8'hA5);
    check("A5 perr",     bus.parity_error, 1'b0);
    check("A5 ferr",     bus.frame_error,  1'b0);
    idle(1);
    check("A5 valid low", bus.valid,       1'b0);

    // Wrong parity bit on 0xA5
    send_frame(8'hA5, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(1);
    check("A5 bad perr", bus.parity_error, 1'b1);
    check("A5 bad data", bus.data_out,     8'hA5);
    idle(2);

    // No parity, parity input toggled mid-frame
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(1);
    check("3C data", bus.data_out,     8'h3C);
    check("3C perr", bus.parity_error, 1'b0);
    check("3C edge", last_v - q.size(), last_v);
    idle(2);

    // Stop bit low on 0x81
    send_frame(8'h81, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1);
    check("81 data", bus.data_out,    8'h81);
    check("81 ferr", bus.frame_error, FCHK);
    idle(2);

    // Back-to-back frames
    send_frame(8'h12, 1'b1, 1'b0, 1'b1, 1'b0);
    send_frame(8'hFE, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(1);
    check("b2b spacing", last_v - prev_v, 11);
    check("b2b data",    bus.data_out,    8'hFE);
    idle(2);

    // Reset in the middle of a frame, then a clean 0x55
    d = 8'h55;
    @(negedge clk);
    bus.parity  = 1'b1;
    bus.data_in = 1'b0;
    ab.start = edge_n + 1;
    ab.due   = edge_n + 100000;
    ab.data  = 8'h00;
    ab.perr  = 1'b0;
    ab.ferr  = 1'b0;
    q.push_back(ab);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.data_in = d[i];
    end
    @(negedge clk);
    reset = 1'b0;
    q.delete();
    exp_data = 8'h00;
    exp_perr = 1'b0;
    exp_ferr = 1'b0;
    bus.data_in = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    check("abort data",  bus.data_out, 8'h00);
    check("abort valid", bus.valid,    1'b0);
    check("abort busy",  bus.busy,     1'b0);
    idle(2);
    send_frame(8'h55, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(1);
    check("55 data",  bus.data_out, 8'h55);
    check("55 valid", bus.valid,    1'b1);
    idle(1);

    // Randomized frames with random gaps, including back-to-back
    for (int f = 0; f < 40; f++) begin
      send_frame(8'($urandom), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)));
      idle($urandom_range(0, 2));
    end
    idle(1);

    for (int w = 0; w < 30 && q.size() > 0; w++) idle(1);
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d frames still pending, expected 0", q.size());
    end
    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
